// File: rtl/ft245_sync_responder.sv
// Device-side (FTDI chip end) model of the FT245 synchronous FIFO bus: sources PC->FPGA bytes
// onto the bus, sinks FPGA->PC writes, and counts host protocol violations.
module ft245_sync_responder #(
  parameter int unsigned DEPTH_LOG2   = 9,
  parameter int unsigned TX_HEADROOM  = 4,
  parameter int unsigned RX_BURST_MAX = 64,
  parameter int unsigned RX_GAP       = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  src_data,
  input  logic        src_valid,
  output logic        src_ready,
  output logic [7:0]  sink_data,
  output logic        sink_valid,
  input  logic        sink_ready,
  input  logic        suspend,
  inout  wire  [7:0]  ftdi_data,
  output logic        ftdi_rde_n,
  output logic        ftdi_txe_n,
  input  logic        ftdi_rd_n,
  input  logic        ftdi_wr_n,
  input  logic        ftdi_oe_n,
  output logic        ftdi_suspend_n,
  input  logic        ftdi_siwu,
  output logic [15:0] err_overrun,
  output logic [15:0] err_underrun,
  output logic [15:0] err_contention,
  output logic        siwu_seen
);

  localparam int unsigned DEPTH   = 1 << DEPTH_LOG2;
  localparam int unsigned CNT_W   = DEPTH_LOG2 + 1;
  localparam int unsigned BURST_W = $clog2(RX_BURST_MAX + 2);
  localparam int unsigned GAP_W   = $clog2(RX_GAP + 2);

  localparam logic [CNT_W-1:0]   CNT_FULL   = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]   TX_HIGH    = CNT_W'(DEPTH - TX_HEADROOM);
  localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(RX_BURST_MAX);
  localparam logic [GAP_W-1:0]   GAP_LAST   = GAP_W'(RX_GAP);

  typedef enum logic [1:0] {RX_IDLE, RX_AVAIL, RX_IN_GAP} rx_state_t;

  rx_state_t             rx_state;
  logic [7:0]            rx_mem [DEPTH];
  logic [7:0]            tx_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] rx_wr_ptr, rx_rd_ptr, tx_wr_ptr, tx_rd_ptr;
  logic [CNT_W-1:0]      rx_count, tx_count;
  logic [BURST_W-1:0]    burst_cnt;
  logic [GAP_W-1:0]      gap_cnt;
  logic [7:0]            bus_q;

  logic                  rx_push, rx_pop, tx_push, tx_pop, tx_full, tx_drop;
  logic                  underrun, contention, burst_hit, gap_done;
  logic [CNT_W-1:0]      rx_count_nxt, tx_count_nxt;
  logic [DEPTH_LOG2-1:0] rx_rd_ptr_nxt, tx_rd_ptr_nxt;
  logic [7:0]            rx_head_nxt, tx_head_nxt;
  logic [BURST_W-1:0]    burst_inc;
  logic [GAP_W-1:0]      gap_inc;

  assign ftdi_data = ftdi_oe_n ? 8'bz : bus_q;

  // FIFO bookkeeping; the next head is bypassed from the write port when the push lands on it
  assign rx_push       = src_valid && src_ready;
  assign rx_pop        = (rx_state == RX_AVAIL) && !ftdi_rd_n && !ftdi_oe_n && (rx_count != '0);
  assign rx_count_nxt  = rx_count + CNT_W'(rx_push) - CNT_W'(rx_pop);
  assign rx_rd_ptr_nxt = rx_rd_ptr + DEPTH_LOG2'(rx_pop);
  assign rx_head_nxt   = (rx_push && (rx_wr_ptr == rx_rd_ptr_nxt)) ? src_data : rx_mem[rx_rd_ptr_nxt];

  assign tx_full       = (tx_count == CNT_FULL);
  assign tx_push       = !ftdi_wr_n && !tx_full;
  assign tx_drop       = !ftdi_wr_n && tx_full;
  assign tx_pop        = sink_valid && sink_ready;
  assign tx_count_nxt  = tx_count + CNT_W'(tx_push) - CNT_W'(tx_pop);
  assign tx_rd_ptr_nxt = tx_rd_ptr + DEPTH_LOG2'(tx_pop);
  assign tx_head_nxt   = (tx_push && (tx_wr_ptr == tx_rd_ptr_nxt)) ? ftdi_data : tx_mem[tx_rd_ptr_nxt];

  assign underrun   = ftdi_rde_n && !ftdi_rd_n && !ftdi_oe_n;
  assign contention = !ftdi_oe_n && !ftdi_wr_n;
  assign burst_inc  = burst_cnt + BURST_W'(1);
  assign burst_hit  = (RX_BURST_MAX != 0) && (burst_inc == BURST_LAST);
  assign gap_inc    = gap_cnt + GAP_W'(1);
  assign gap_done   = (gap_inc >= GAP_LAST);

  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
    return (en && (v != 16'hFFFF)) ? v + 16'd1 : v;
  endfunction

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wr_ptr] <= src_data;
    if (tx_push) tx_mem[tx_wr_ptr] <= ftdi_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state       <= RX_IDLE;
      rx_wr_ptr      <= '0;
      rx_rd_ptr      <= '0;
      tx_wr_ptr      <= '0;
      tx_rd_ptr      <= '0;
      rx_count       <= '0;
      tx_count       <= '0;
      burst_cnt      <= '0;
      gap_cnt        <= '0;
      bus_q          <= '0;
      sink_data      <= '0;
      sink_valid     <= 1'b0;
      src_ready      <= 1'b0;
      ftdi_rde_n     <= 1'b1;
      ftdi_txe_n     <= 1'b1;
      ftdi_suspend_n <= 1'b1;
      err_overrun    <= '0;
      err_underrun   <= '0;
      err_contention <= '0;
      siwu_seen      <= 1'b0;
    end else begin
      rx_wr_ptr      <= rx_wr_ptr + DEPTH_LOG2'(rx_push);
      rx_rd_ptr      <= rx_rd_ptr_nxt;
      rx_count       <= rx_count_nxt;
      bus_q          <= rx_head_nxt;
      src_ready      <= (rx_count_nxt != CNT_FULL);
      tx_wr_ptr      <= tx_wr_ptr + DEPTH_LOG2'(tx_push);
      tx_rd_ptr      <= tx_rd_ptr_nxt;
      tx_count       <= tx_count_nxt;
      sink_data      <= tx_head_nxt;
      sink_valid     <= (tx_count_nxt != '0);
      ftdi_txe_n     <= suspend || (tx_count_nxt >= TX_HIGH);
      ftdi_suspend_n <= !suspend;
      err_overrun    <= sat_inc(err_overrun, tx_drop);
      err_underrun   <= sat_inc(err_underrun, underrun);
      err_contention <= sat_inc(err_contention, contention);
      if (!ftdi_siwu) siwu_seen <= 1'b1;

      // RX burst sequencer; a gap with data pending re-opens directly so rde_n is high exactly RX_GAP cycles
      case (rx_state)
        RX_IDLE: begin
          if ((rx_count != '0) && !suspend) begin
            rx_state   <= RX_AVAIL;
            ftdi_rde_n <= 1'b0;
          end
        end
        RX_AVAIL: begin
          if (rx_pop) begin
            burst_cnt <= burst_inc;
            if ((rx_count_nxt == '0) || burst_hit) begin
              rx_state   <= RX_IN_GAP;
              ftdi_rde_n <= 1'b1;
              burst_cnt  <= '0;
              gap_cnt    <= '0;
            end
          end
        end
        RX_IN_GAP: begin
          burst_cnt <= '0;
          gap_cnt   <= gap_inc;
          if (gap_done) begin
            if ((rx_count != '0) && !suspend) begin
              rx_state   <= RX_AVAIL;
              ftdi_rde_n <= 1'b0;
            end else begin
              rx_state <= RX_IDLE;
            end
          end
        end
        default: begin
          rx_state   <= RX_IDLE;
          ftdi_rde_n <= 1'b1;
        end
      endcase

      // Suspend aborts any burst; queued bytes stay in the FIFO
      if (suspend) begin
        rx_state   <= RX_IDLE;
        ftdi_rde_n <= 1'b1;
        burst_cnt  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ft245_sync_responder.sv
// Directed bench for ft245_sync_responder: an ideal host drives the FT245 strobes and
// hand-computed bytes, flags and counter values are compared each scenario.
module tb_ft245_sync_responder;

  localparam int unsigned DEPTH_LOG2   = 4;
  localparam int unsigned TX_HEADROOM  = 4;
  localparam int unsigned RX_BURST_MAX = 4;
  localparam int unsigned RX_GAP       = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  src_data;
  logic        src_valid;
  logic        src_ready;
  logic [7:0]  sink_data;
  logic        sink_valid;
  logic        sink_ready;
  logic        suspend;
  wire  [7:0]  ftdi_data;
  logic        ftdi_rde_n, ftdi_txe_n, ftdi_suspend_n;
  logic        rd_n, wr_n, oe_n, siwu;
  logic [15:0] err_overrun, err_underrun, err_contention;
  logic        siwu_seen;
  logic        host_drv;
  logic [7:0]  host_data;

  int checks = 0;
  int passed = 0;

  assign ftdi_data = host_drv ? host_data : 8'bz;

  ft245_sync_responder #(
    .DEPTH_LOG2(DEPTH_LOG2), .TX_HEADROOM(TX_HEADROOM),
    .RX_BURST_MAX(RX_BURST_MAX), .RX_GAP(RX_GAP)
  ) dut (
    .clk(clk), .rst(rst),
    .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
    .sink_data(sink_data), .sink_valid(sink_valid), .sink_ready(sink_ready),
    .suspend(suspend), .ftdi_data(ftdi_data),
    .ftdi_rde_n(ftdi_rde_n), .ftdi_txe_n(ftdi_txe_n),
    .ftdi_rd_n(rd_n), .ftdi_wr_n(wr_n), .ftdi_oe_n(oe_n),
    .ftdi_suspend_n(ftdi_suspend_n), .ftdi_siwu(siwu),
    .err_overrun(err_overrun), .err_underrun(err_underrun),
    .err_contention(err_contention), .siwu_seen(siwu_seen)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_bytes(input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      src_valid = 1'b1;
      src_data  = first + 8'(i);
      step();
    end
    src_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; src_valid = 1'b0; src_data = '0; sink_ready = 1'b0; suspend = 1'b0;
    siwu = 1'b1; rd_n = 1'b1; wr_n = 1'b1; oe_n = 1'b1; host_drv = 1'b0; host_data = '0;
    step(); step();
    checks++; if (ftdi_rde_n !== 1'b1) $display("FAIL reset_rde_n: got %0b want 1", ftdi_rde_n); else passed++;
    checks++; if (ftdi_txe_n !== 1'b1) $display("FAIL reset_txe_n: got %0b want 1", ftdi_txe_n); else passed++;
    checks++; if (ftdi_suspend_n !== 1'b1) $display("FAIL reset_suspend_n: got %0b want 1", ftdi_suspend_n); else passed++;
    checks++; if (sink_valid !== 1'b0) $display("FAIL reset_sink_valid: got %0b want 0", sink_valid); else passed++;
    checks++; if (src_ready !== 1'b0) $display("FAIL reset_src_ready: got %0b want 0", src_ready); else passed++;
    checks++; if ({err_overrun, err_underrun, err_contention} !== 48'h0)
      $display("FAIL reset_errs: got %h/%h/%h want 0/0/0", err_overrun, err_underrun, err_contention); else passed++;
    checks++; if (siwu_seen !== 1'b0) $display("FAIL reset_siwu_seen: got %0b want 0", siwu_seen); else passed++;
    rst = 1'b0;
    step();
    checks++; if (src_ready !== 1'b1) $display("FAIL post_reset_src_ready: got %0b want 1", src_ready); else passed++;
    checks++; if (ftdi_txe_n !== 1'b0) $display("FAIL post_reset_txe_n: got %0b want 0", ftdi_txe_n); else passed++;
    checks++; if (ftdi_rde_n !== 1'b1) $display("FAIL post_reset_rde_n: got %0b want 1", ftdi_rde_n); else passed++;
  endtask

  task automatic test_rx_burst();
    push_bytes(8'h10, 4);
    checks++; if (ftdi_rde_n !== 1'b0) $display("FAIL rx_avail_rde_n: got %0b want 0", ftdi_rde_n); else passed++;
    oe_n = 1'b0; rd_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (ftdi_data !== 8'h10 + 8'(i))
        $display("FAIL rx_burst_byte%0d: got %h want %h", i, ftdi_data, 8'h10 + 8'(i)); else passed++;
      step();
    end
    rd_n = 1'b1; oe_n = 1'b1;
    checks++; if (ftdi_rde_n !== 1'b1) $display("FAIL rx_burst_end_rde_n: got %0b want 1", ftdi_rde_n); else passed++;
    checks++; if (err_underrun !== 16'd0) $display("FAIL rx_burst_underrun: got %0d want 0", err_underrun); else passed++;
  endtask

  task automatic test_burst_gap();
    int got = 0;
    int hi_run = 0;
    int gaps[$];
    int g0, g1;
    push_bytes(8'h20, 10);
    oe_n = 1'b0;
    for (int c = 0; c < 40 && got < 10; c++) begin
      rd_n = ftdi_rde_n;
      if (ftdi_rde_n) hi_run++;
      else begin
        if (hi_run > 0) gaps.push_back(hi_run);
        hi_run = 0;
      end
      #1;
      if (!rd_n) begin
        checks++; if (ftdi_data !== 8'h20 + 8'(got))
          $display("FAIL gap_byte%0d: got %h want %h", got, ftdi_data, 8'h20 + 8'(got)); else passed++;
        got++;
      end
      step();
    end
    rd_n = 1'b1; oe_n = 1'b1;
    g0 = (gaps.size() > 0) ? gaps[0] : -1;
    g1 = (gaps.size() > 1) ? gaps[1] : -1;
    checks++; if (got !== 10) $display("FAIL gap_byte_count: got %0d want 10", got); else passed++;
    checks++; if (gaps.size() !== 2) $display("FAIL gap_count: got %0d want 2", gaps.size()); else passed++;
    checks++; if (g0 !== 2) $display("FAIL gap_len_after4: got %0d want 2", g0); else passed++;
    checks++; if (g1 !== 2) $display("FAIL gap_len_after8: got %0d want 2", g1); else passed++;
    checks++; if (err_underrun !== 16'd0) $display("FAIL gap_underrun: got %0d want 0", err_underrun); else passed++;
  endtask

  task automatic test_tx_write();
    sink_ready = 1'b1;
    checks++; if (sink_valid !== 1'b0) $display("FAIL tx_idle_valid: got %0b want 0", sink_valid); else passed++;
    host_drv = 1'b1; wr_n = 1'b0; host_data = 8'hA5;
    step();
    checks++; if (sink_valid !== 1'b1 || sink_data !== 8'hA5)
      $display("FAIL tx_first: got v=%0b d=%h want v=1 d=a5", sink_valid, sink_data); else passed++;
    host_data = 8'h5A;
    step();
    checks++; if (sink_valid !== 1'b1 || sink_data !== 8'h5A)
      $display("FAIL tx_second: got v=%0b d=%h want v=1 d=5a", sink_valid, sink_data); else passed++;
    wr_n = 1'b1; host_drv = 1'b0;
    step();
    checks++; if (sink_valid !== 1'b0) $display("FAIL tx_drained: got %0b want 0", sink_valid); else passed++;
  endtask

  task automatic test_tx_headroom();
    int n = 0;
    sink_ready = 1'b0; host_drv = 1'b1; wr_n = 1'b0;
    while (ftdi_txe_n == 1'b0 && n < 40) begin
      host_data = 8'(n);
      step();
      n++;
    end
    checks++; if (n !== 12) $display("FAIL tx_txe_deassert_at: got %0d writes want 12", n); else passed++;
    checks++; if (err_overrun !== 16'd0) $display("FAIL tx_no_early_overrun: got %0d want 0", err_overrun); else passed++;
    for (int i = 0; i < 6; i++) begin
      host_data = 8'(12 + i);
      step();
    end
    wr_n = 1'b1; host_drv = 1'b0;
    checks++; if (err_overrun !== 16'd2) $display("FAIL tx_overrun: got %0d want 2", err_overrun); else passed++;
    checks++; if (ftdi_txe_n !== 1'b1) $display("FAIL tx_full_txe_n: got %0b want 1", ftdi_txe_n); else passed++;
    sink_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      checks++; if (sink_valid !== 1'b1 || sink_data !== 8'(i))
        $display("FAIL tx_drain%0d: got v=%0b d=%h want v=1 d=%h", i, sink_valid, sink_data, 8'(i)); else passed++;
      step();
    end
    checks++; if (sink_valid !== 1'b0) $display("FAIL tx_drain_empty: got %0b want 0", sink_valid); else passed++;
    checks++; if (ftdi_txe_n !== 1'b0) $display("FAIL tx_drain_txe_n: got %0b want 0", ftdi_txe_n); else passed++;
  endtask

  task automatic test_contention_underrun();
    host_drv = 1'b1; host_data = 8'h3C; oe_n = 1'b0; wr_n = 1'b0;
    step(); step(); step();
    wr_n = 1'b1; oe_n = 1'b1; host_drv = 1'b0;
    checks++; if (err_contention !== 16'd3) $display("FAIL contention_count: got %0d want 3", err_contention); else passed++;
    checks++; if (err_overrun !== 16'd2) $display("FAIL contention_overrun: got %0d want 2", err_overrun); else passed++;
    step(); step();
    checks++; if (sink_valid !== 1'b0) $display("FAIL contention_drained: got %0b want 0", sink_valid); else passed++;
    push_bytes(8'h77, 1);
    rd_n = 1'b0; oe_n = 1'b0;
    step();
    checks++; if (err_underrun !== 16'd1) $display("FAIL underrun_count: got %0d want 1", err_underrun); else passed++;
    checks++; if (ftdi_rde_n !== 1'b0) $display("FAIL underrun_then_avail: got %0b want 0", ftdi_rde_n); else passed++;
    checks++; if (ftdi_data !== 8'h77) $display("FAIL underrun_no_pop: got %h want 77", ftdi_data); else passed++;
    step();
    rd_n = 1'b1; oe_n = 1'b1;
    checks++; if (ftdi_rde_n !== 1'b1) $display("FAIL underrun_single_byte: got %0b want 1", ftdi_rde_n); else passed++;
    checks++; if (err_underrun !== 16'd1) $display("FAIL underrun_stable: got %0d want 1", err_underrun); else passed++;
  endtask

  task automatic test_siwu();
    checks++; if (siwu_seen !== 1'b0) $display("FAIL siwu_before: got %0b want 0", siwu_seen); else passed++;
    siwu = 1'b0;
    step();
    siwu = 1'b1;
    checks++; if (siwu_seen !== 1'b1) $display("FAIL siwu_set: got %0b want 1", siwu_seen); else passed++;
    step();
    checks++; if (siwu_seen !== 1'b1) $display("FAIL siwu_sticky: got %0b want 1", siwu_seen); else passed++;
  endtask

  task automatic test_suspend_reset();
    push_bytes(8'h30, 3);
    checks++; if (ftdi_rde_n !== 1'b0) $display("FAIL susp_pre_rde_n: got %0b want 0", ftdi_rde_n); else passed++;
    oe_n = 1'b0; rd_n = 1'b0;
    step();
    suspend = 1'b1; rd_n = 1'b1; oe_n = 1'b1;
    step();
    checks++; if (ftdi_rde_n !== 1'b1) $display("FAIL susp_rde_n: got %0b want 1", ftdi_rde_n); else passed++;
    checks++; if (ftdi_txe_n !== 1'b1) $display("FAIL susp_txe_n: got %0b want 1", ftdi_txe_n); else passed++;
    checks++; if (ftdi_suspend_n !== 1'b0) $display("FAIL susp_suspend_n: got %0b want 0", ftdi_suspend_n); else passed++;
    step(); step();
    checks++; if (ftdi_rde_n !== 1'b1) $display("FAIL susp_hold_rde_n: got %0b want 1", ftdi_rde_n); else passed++;
    suspend = 1'b0;
    step();
    checks++; if (ftdi_rde_n !== 1'b0 || ftdi_txe_n !== 1'b0 || ftdi_suspend_n !== 1'b1)
      $display("FAIL resume_flags: got rde=%0b txe=%0b sus=%0b want 0 0 1", ftdi_rde_n, ftdi_txe_n, ftdi_suspend_n); else passed++;
    oe_n = 1'b0;
    #1;
    checks++; if (ftdi_data !== 8'h31) $display("FAIL resume_head: got %h want 31", ftdi_data); else passed++;
    rd_n = 1'b0;
    step();
    rst = 1'b1;
    step();
    checks++; if (ftdi_rde_n !== 1'b1 || ftdi_txe_n !== 1'b1 || ftdi_suspend_n !== 1'b1)
      $display("FAIL rst_flags: got rde=%0b txe=%0b sus=%0b want 1 1 1", ftdi_rde_n, ftdi_txe_n, ftdi_suspend_n); else passed++;
    checks++; if (src_ready !== 1'b0 || sink_valid !== 1'b0)
      $display("FAIL rst_user: got rdy=%0b vld=%0b want 0 0", src_ready, sink_valid); else passed++;
    checks++; if ({err_overrun, err_underrun, err_contention} !== 48'h0 || siwu_seen !== 1'b0)
      $display("FAIL rst_errs: got %h/%h/%h siwu=%0b want 0", err_overrun, err_underrun, err_contention, siwu_seen); else passed++;
    rst = 1'b0; rd_n = 1'b1; oe_n = 1'b1;
    step(); step(); step();
    checks++; if (ftdi_rde_n !== 1'b1) $display("FAIL rst_flushed_rx: got %0b want 1", ftdi_rde_n); else passed++;
    checks++; if (src_ready !== 1'b1 || sink_valid !== 1'b0)
      $display("FAIL rst_after_user: got rdy=%0b vld=%0b want 1 0", src_ready, sink_valid); else passed++;
  endtask

  initial begin
    test_reset();
    test_rx_burst();
    test_burst_gap();
    test_tx_write();
    test_tx_headroom();
    test_contention_underrun();
    test_siwu();
    test_suspend_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
